// File: rtl/io_file_responder.sv
// rtl/io_file_responder.sv - IO-file responder: byte TX FIFO + UART serializer, RX byte FIFO read port
//
// Purpose: serves IO-file writes by queuing bytes for an 8N1 UART transmitter and
// serves IO-file reads by popping bytes offered on an external ready/valid port.
//
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   out_req, out_data     write strobe and payload (bits [7:0] queued for TX)
//   in_req, in_data       read strobe and registered read result
//   rx_valid, rx_data     external byte offer into the RX FIFO
//   rx_ready              RX FIFO not full
//   txd                   UART serial line, idle high
//   tx_overflow           sticky: a write was dropped on a full TX FIFO
//   tx_busy               TX FIFO holds data or a frame is in flight
module io_file_responder #(
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] EMPTY_WORD   = 32'hffffffff
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        out_req,
  input  logic [31:0] out_data,
  input  logic        in_req,
  output logic [31:0] in_data,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        txd,
  output logic        tx_overflow,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  logic unused_out_hi;
  assign unused_out_hi = ^out_data[31:8];

  // ---------------- TX FIFO ----------------
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr_q, tx_rd_q;
  logic        tx_empty, tx_full, tx_push, tx_pop;
  logic        tx_overflow_q;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  // Same index but different wrap bit means the writer is a full lap ahead.
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign tx_push  = out_req && !tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= out_data[7:0];
  end

  // ---------------- Serializer ----------------
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          baud_done;

  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_pop  = 1'b0;
    txd     = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          shift_d = tx_mem[tx_rd_q[AW-1:0]];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        txd = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        txd = shift_q[0];
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next frame so queued bytes go out gap-free.
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            shift_d = tx_mem[tx_rd_q[AW-1:0]];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wr_q       <= '0;
      tx_rd_q       <= '0;
      tx_overflow_q <= 1'b0;
      state_q       <= S_IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
    end else begin
      if (tx_push)            tx_wr_q       <= tx_wr_q + (AW+1)'(1);
      if (tx_pop)             tx_rd_q       <= tx_rd_q + (AW+1)'(1);
      if (out_req && tx_full) tx_overflow_q <= 1'b1;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign tx_overflow = tx_overflow_q;
  assign tx_busy     = !tx_empty || (state_q != S_IDLE);

  // ---------------- RX FIFO ----------------
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wr_q, rx_rd_q;
  logic        rx_empty, rx_full, rx_push, rx_pop;
  logic [31:0] in_data_q;

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign rx_ready = !rx_full;
  assign rx_pop   = in_req && !rx_empty;
  // A read on a full FIFO frees the head slot on the same edge, so the offered
  // byte is accepted even though rx_ready is low.
  assign rx_push  = rx_valid && (!rx_full || rx_pop);

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      in_data_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + (AW+1)'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + (AW+1)'(1);
      if (in_req)  in_data_q <= rx_empty ? EMPTY_WORD : {24'h0, rx_mem[rx_rd_q[AW-1:0]]};
    end
  end

  assign in_data = in_data_q;

endmodule

// File: tb/tb_io_file_responder.sv
// tb/tb_io_file_responder.sv - directed self-checking bench for io_file_responder
module tb_io_file_responder;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic        clk      = 1'b0;
  logic        rstn     = 1'b0;
  logic        out_req  = 1'b0;
  logic [31:0] out_data = 32'h0;
  logic        in_req   = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h0;
  logic [31:0] in_data;
  logic        rx_ready, txd, tx_overflow, tx_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  io_file_responder #(
    .FIFO_DEPTH  (DEPTH),
    .CLKS_PER_BIT(CPB),
    .EMPTY_WORD  (32'hffffffff)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .out_req    (out_req),
    .out_data   (out_data),
    .in_req     (in_req),
    .in_data    (in_data),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .txd        (txd),
    .tx_overflow(tx_overflow),
    .tx_busy    (tx_busy)
  );

  task automatic test_reset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b want 1", txd); end
    n_cmp++; if (in_data !== 32'h0) begin n_bad++; $display("FAIL reset_in_data: got %h want 00000000", in_data); end
    n_cmp++; if (tx_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_tx_overflow: got %b want 0", tx_overflow); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++; if (txd !== 1'b1 || tx_busy !== 1'b0) begin n_bad++; $display("FAIL post_release_idle: txd=%b busy=%b want 1/0", txd, tx_busy); end
    n_cmp++; if (in_data !== 32'h0) begin n_bad++; $display("FAIL post_release_in_data: got %h want 00000000", in_data); end
  endtask

  task automatic test_single_tx(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    @(negedge clk);
    out_req  = 1'b1;
    out_data = {24'hABCDEF, b};
    @(negedge clk);
    out_req  = 1'b0;
    out_data = 32'h0;
    n_cmp++; if (tx_busy !== 1'b1) begin n_bad++; $display("FAIL tx_busy_after_push: got %b want 1", tx_busy); end
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL txd_before_pop: got %b want 1", txd); end
    for (int k = 0; k < 10*CPB; k++) begin
      @(negedge clk);
      n_cmp++;
      if (txd !== frame[k/CPB]) begin
        n_bad++; $display("FAIL tx_frame_%h cycle %0d: got %b want %b", b, k, txd, frame[k/CPB]);
      end
      if (k == 10*CPB-1) begin
        n_cmp++; if (tx_busy !== 1'b1) begin n_bad++; $display("FAIL tx_busy_last_cycle: got %b want 1", tx_busy); end
      end
    end
    @(negedge clk);
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL tx_busy_after_frame: got %b want 0", tx_busy); end
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL txd_after_frame: got %b want 1", txd); end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] lead;
    logic [7:0] d [17];
    logic [7:0] eb;
    logic [9:0] obs_f, exp_f;
    int f;
    lead  = 8'h5C;
    obs_f = '0;
    for (int i = 0; i < 17; i++) d[i] = 8'(i*37 + 3);
    @(negedge clk);
    out_req  = 1'b1;
    out_data = {24'h0, lead};
    @(negedge clk);
    out_req  = 1'b0;
    for (int k = 0; k < 17*10*CPB; k++) begin
      @(negedge clk);
      if ((k % CPB) == CPB/2) obs_f[(k % (10*CPB))/CPB] = txd;
      if ((k % (10*CPB)) == 10*CPB-1) begin
        f     = k / (10*CPB);
        eb    = (f == 0) ? lead : d[f-1];
        exp_f = {1'b1, eb, 1'b0};
        n_cmp++;
        if (obs_f !== exp_f) begin n_bad++; $display("FAIL tx_stream_frame %0d: got %b want %b", f, obs_f, exp_f); end
      end
      if (k == 16) begin
        n_cmp++; if (tx_overflow !== 1'b0) begin n_bad++; $display("FAIL overflow_before_17th: got %b want 0", tx_overflow); end
      end
      if (k == 17) begin
        n_cmp++; if (tx_overflow !== 1'b1) begin n_bad++; $display("FAIL overflow_after_17th: got %b want 1", tx_overflow); end
      end
      if (k < 17) begin
        out_req  = 1'b1;
        out_data = {24'h0, d[k]};
      end else begin
        out_req  = 1'b0;
        out_data = 32'h0;
      end
    end
    @(negedge clk);
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_burst: got %b want 0", tx_busy); end
    n_cmp++; if (tx_overflow !== 1'b1) begin n_bad++; $display("FAIL overflow_sticky: got %b want 1", tx_overflow); end
  endtask

  task automatic test_rx_read();
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h41;
    @(negedge clk);
    rx_data = 8'h42;
    @(negedge clk);
    rx_valid = 1'b0; in_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_data !== 32'h00000041) begin n_bad++; $display("FAIL rx_read_first: got %h want 00000041", in_data); end
    @(negedge clk);
    in_req = 1'b0;
    n_cmp++; if (in_data !== 32'h00000042) begin n_bad++; $display("FAIL rx_read_second: got %h want 00000042", in_data); end
    @(negedge clk);
    n_cmp++; if (in_data !== 32'h00000042) begin n_bad++; $display("FAIL rx_read_hold: got %h want 00000042", in_data); end
  endtask

  task automatic test_empty_read();
    @(negedge clk);
    in_req = 1'b1;
    @(negedge clk);
    in_req = 1'b0;
    n_cmp++; if (in_data !== 32'hffffffff) begin n_bad++; $display("FAIL empty_read: got %h want ffffffff", in_data); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL empty_rx_ready: got %b want 1", rx_ready); end
    @(negedge clk);
    in_req = 1'b1; rx_valid = 1'b1; rx_data = 8'h5A;
    @(negedge clk);
    in_req = 1'b0; rx_valid = 1'b0;
    n_cmp++; if (in_data !== 32'hffffffff) begin n_bad++; $display("FAIL empty_read_with_push: got %h want ffffffff", in_data); end
    in_req = 1'b1;
    @(negedge clk);
    in_req = 1'b0;
    n_cmp++; if (in_data !== 32'h0000005A) begin n_bad++; $display("FAIL pushed_byte_kept: got %h want 0000005a", in_data); end
    @(negedge clk);
    in_req = 1'b1;
    @(negedge clk);
    in_req = 1'b0;
    n_cmp++; if (in_data !== 32'hffffffff) begin n_bad++; $display("FAIL empty_again: got %h want ffffffff", in_data); end
  endtask

  task automatic test_rx_full();
    logic [7:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (i == DEPTH-1) begin
        n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL rx_ready_one_free: got %b want 1", rx_ready); end
      end
      rx_valid = 1'b1; rx_data = 8'(8'h80 + i);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL rx_ready_full: got %b want 0", rx_ready); end
    // Read + push on a full FIFO, with a TX write in the same cycle.
    rx_valid = 1'b1; rx_data = 8'hC0; in_req = 1'b1;
    out_req = 1'b1; out_data = 32'h0000003C;
    #1;
    n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL rx_ready_during_swap: got %b want 0", rx_ready); end
    @(negedge clk);
    rx_valid = 1'b0; in_req = 1'b0; out_req = 1'b0; out_data = 32'h0;
    n_cmp++; if (in_data !== 32'h00000080) begin n_bad++; $display("FAIL full_swap_head: got %h want 00000080", in_data); end
    n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL full_swap_still_full: got %b want 0", rx_ready); end
    n_cmp++; if (tx_busy !== 1'b1) begin n_bad++; $display("FAIL concurrent_tx_write: got %b want 1", tx_busy); end
    in_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (i == DEPTH-1) in_req = 1'b0;
      e = (i < DEPTH-1) ? 8'(8'h81 + i) : 8'hC0;
      n_cmp++;
      if (in_data !== {24'h0, e}) begin n_bad++; $display("FAIL drain_%0d: got %h want %h", i, in_data, {24'h0, e}); end
    end
    n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL rx_ready_drained: got %b want 1", rx_ready); end
    @(negedge clk);
    in_req = 1'b1;
    @(negedge clk);
    in_req = 1'b0;
    n_cmp++; if (in_data !== 32'hffffffff) begin n_bad++; $display("FAIL drained_empty_read: got %h want ffffffff", in_data); end
  endtask

  task automatic test_reset_midframe();
    for (int c = 0; c < 200 && tx_busy; c++) @(negedge clk);
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL wait_idle_timeout: busy=%b want 0", tx_busy); end
    @(negedge clk);
    out_req = 1'b1; out_data = 32'h000000A5;
    rx_valid = 1'b1; rx_data = 8'h77;
    @(negedge clk);
    out_req = 1'b0; out_data = 32'h0; rx_valid = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    // Cycle 9 of the frame is data bit 1 of A5, which is 0.
    n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL midframe_data_bit: got %b want 0", txd); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL async_reset_txd: got %b want 1", txd); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy: got %b want 0", tx_busy); end
    n_cmp++; if (in_data !== 32'h0) begin n_bad++; $display("FAIL async_reset_in_data: got %h want 00000000", in_data); end
    n_cmp++; if (tx_overflow !== 1'b0) begin n_bad++; $display("FAIL async_reset_overflow: got %b want 0", tx_overflow); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++; if (txd !== 1'b1 || tx_busy !== 1'b0) begin n_bad++; $display("FAIL after_reset_idle: txd=%b busy=%b want 1/0", txd, tx_busy); end
    in_req = 1'b1;
    @(negedge clk);
    in_req = 1'b0;
    n_cmp++; if (in_data !== 32'hffffffff) begin n_bad++; $display("FAIL rx_discarded: got %h want ffffffff", in_data); end
    test_single_tx(8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_tx(8'hA5);
    test_tx_overflow();
    test_rx_read();
    test_empty_read();
    test_rx_full();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
